uart_rx_sampler_deser: RTL and testbench

//   Downstream consumer of the UART RX edge/bit counter. Oversamples RX_IN at three points

---
 rtl/uart_rx_sampler_deser.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_sampler_deser.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler_deser.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sampler_deser
// Description : Votes three mid-bit samples of RX_IN and assembles UART frames,
//               flagging start glitches, parity errors and stop errors.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sampler_deser #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            Prescale,
    input  logic                  RX_IN,
    input  logic                  sample_enable,
    input  logic [4:0]            edge_count,
    input  logic [3:0]            bit_count,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  strt_glitch,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_active = 2'd1;
    localparam logic [1:0] c_st_abort  = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    localparam logic [3:0] c_idx_par      = 4'(DATA_WIDTH + 1);
    localparam logic [3:0] c_idx_stop_par = 4'(DATA_WIDTH + 2);

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic                  w_in_idle;
    logic                  w_in_active;
    logic                  w_pre_ok;
    logic                  w_sample_en;
    logic [5:0]            w_mid;
    logic [5:0]            w_edge;
    logic                  r_s0;
    logic                  r_s1;
    logic                  r_s2;
    logic [3:0]            r_bit_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_bad;
    logic                  w_proc;
    logic [3:0]            w_stop_idx;
    logic                  w_par_exp;
    logic                  w_glitch;
    logic                  w_par_bad;
    logic                  w_stop_hit;

    assign w_pre_ok    = (Prescale == 6'd8) || (Prescale == 6'd16) || (Prescale == 6'd32);
    assign w_sample_en = sample_enable && w_pre_ok;
    assign w_mid       = {1'b0, Prescale[5:1]};
    assign w_edge      = {1'b0, edge_count};

    // Frame processing happens on the cycle after the vote, from the latched index
    assign w_proc     = sample_valid && w_in_active && w_sample_en;
    assign w_stop_idx = PAR_EN ? c_idx_stop_par : c_idx_par;
    assign w_par_exp  = PAR_TYP ? ~^r_shift : ^r_shift;
    assign w_glitch   = w_proc && (r_bit_idx == 4'd0) && sampled_bit;
    assign w_par_bad  = w_proc && PAR_EN && (r_bit_idx == c_idx_par) && (sampled_bit != w_par_exp);
    assign w_stop_hit = w_proc && (r_bit_idx == w_stop_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!w_sample_en) begin
            w_state_next = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle:   w_state_next = c_st_active;
                c_st_active: begin
                    if (w_glitch) begin
                        w_state_next = c_st_abort;
                    end else if (w_stop_hit) begin
                        w_state_next = c_st_done;
                    end
                end
                default:     w_state_next = r_state;
            endcase
        end
    end

    always_comb begin
        w_in_idle   = (r_state == c_st_idle);
        w_in_active = (r_state == c_st_active);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0         <= 1'b0;
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_bit_idx    <= 4'd0;
            r_shift      <= '0;
            r_bad        <= 1'b0;
            sampled_bit  <= 1'b0;
            sample_valid <= 1'b0;
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            strt_glitch  <= 1'b0;
            par_err      <= 1'b0;
            stp_err      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            data_valid   <= 1'b0;
            strt_glitch  <= 1'b0;
            par_err      <= 1'b0;
            stp_err      <= 1'b0;

            if (!w_sample_en) begin
                r_s0 <= 1'b0;
                r_s1 <= 1'b0;
                r_s2 <= 1'b0;
            end else begin
                if (w_edge == w_mid - 6'd1) r_s0 <= RX_IN;
                if (w_edge == w_mid)        r_s1 <= RX_IN;
                if (w_edge == w_mid + 6'd1) r_s2 <= RX_IN;
            end

            if (w_sample_en && w_in_active && (w_edge == w_mid + 6'd2)) begin
                sampled_bit  <= (r_s0 & r_s1) | (r_s0 & r_s2) | (r_s1 & r_s2);
                r_bit_idx    <= bit_count;
                sample_valid <= 1'b1;
            end

            // A dropped or finished frame leaves no partial word or bad mark behind
            if (w_in_idle) begin
                r_shift <= '0;
                r_bad   <= 1'b0;
            end else if (w_proc) begin
                for (int i = 0; i < DATA_WIDTH; i++) begin
                    if (r_bit_idx == 4'(i + 1)) r_shift[i] <= sampled_bit;
                end
                if (w_glitch) strt_glitch <= 1'b1;
                if (w_par_bad) begin
                    par_err <= 1'b1;
                    r_bad   <= 1'b1;
                end
                if (w_stop_hit) begin
                    if (!sampled_bit) begin
                        stp_err <= 1'b1;
                    end else if (!r_bad) begin
                        P_DATA     <= r_shift;
                        data_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sampler_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_sampler_deser
// Description : Drives whole UART frames through the sampler/deserialiser and
//               scores received words and flag pulses against expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_sampler_deser;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    Prescale;
    logic          RX_IN;
    logic          sample_enable;
    logic [4:0]    edge_count;
    logic [3:0]    bit_count;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          sampled_bit;
    logic          sample_valid;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          strt_glitch;
    logic          par_err;
    logic          stp_err;

    uart_rx_sampler_deser #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .Prescale     (Prescale),
        .RX_IN        (RX_IN),
        .sample_enable(sample_enable),
        .edge_count   (edge_count),
        .bit_count    (bit_count),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .sampled_bit  (sampled_bit),
        .sample_valid (sample_valid),
        .P_DATA       (P_DATA),
        .data_valid   (data_valid),
        .strt_glitch  (strt_glitch),
        .par_err      (par_err),
        .stp_err      (stp_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Pulse counters and captured words, owned by the monitor
    int cnt_dv = 0, cnt_gl = 0, cnt_par = 0, cnt_stp = 0, cnt_sv = 0;
    logic [DW-1:0] got_q[$];

    // Per-scenario baselines, expected pulse counts and the expected-word scoreboard
    int b_dv, b_gl, b_par, b_stp, b_sv;
    int e_dv, e_gl, e_par, e_stp, e_sv;
    int got_rd = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] want_w;

    always @(negedge clk) begin
        if (!rst) begin
            if (sample_valid) cnt_sv++;
            if (strt_glitch)  cnt_gl++;
            if (par_err)      cnt_par++;
            if (stp_err)      cnt_stp++;
            if (data_valid) begin
                cnt_dv++;
                got_q.push_back(P_DATA);
            end
        end
    end

    function automatic logic [39:0] obs_counts();
        return {8'(cnt_dv - b_dv), 8'(cnt_gl - b_gl), 8'(cnt_par - b_par),
                8'(cnt_stp - b_stp), 8'(cnt_sv - b_sv)};
    endfunction

    function automatic logic [39:0] want_counts();
        return {8'(e_dv), 8'(e_gl), 8'(e_par), 8'(e_stp), 8'(e_sv)};
    endfunction

    task automatic mark();
        b_dv = cnt_dv; b_gl = cnt_gl; b_par = cnt_par; b_stp = cnt_stp; b_sv = cnt_sv;
        e_dv = 0; e_gl = 0; e_par = 0; e_stp = 0; e_sv = 0;
    endtask

    task automatic drive_cycle(input logic se, input logic rx, input logic [4:0] ec,
                               input logic [3:0] bc);
        sample_enable = se;
        RX_IN         = rx;
        edge_count    = ec;
        bit_count     = bc;
        @(posedge clk);
        #1;
    endtask

    // One frame as the edge/bit counter would present it; adds its expectations
    task automatic send_frame(input int pre, input logic [DW-1:0] data, input bit par_en,
                              input bit par_typ, input bit start_one, input bit bad_par,
                              input bit bad_stop, input int glitch_bit, input int glitch_edge,
                              input int drop_after);
        int   nbits;
        logic v;
        logic pbit;
        bit   legal;
        bit   dropped;
        bit   good;
        legal    = (pre == 8) || (pre == 16) || (pre == 32);
        dropped  = (drop_after >= 0);
        nbits    = par_en ? DW + 3 : DW + 2;
        pbit     = (par_typ ? ~^data : ^data) ^ bad_par;
        Prescale = 6'(pre);
        PAR_EN   = par_en;
        PAR_TYP  = par_typ;
        good     = legal && !start_one && !dropped && !(par_en && bad_par) && !bad_stop;
        if (good) exp_q.push_back(data);
        e_dv  += int'(good);
        e_gl  += int'(legal && start_one);
        e_par += int'(legal && !start_one && !dropped && par_en && bad_par);
        e_stp += int'(legal && !start_one && !dropped && bad_stop);
        e_sv  += !legal ? 0 : start_one ? 1 : dropped ? drop_after + 1 : nbits;

        drive_cycle(1'b0, 1'b1, 5'd0, 4'd0);
        for (int b = 0; b < nbits; b++) begin
            if (b == 0)                       v = start_one;
            else if (b <= DW)                 v = data[b-1];
            else if (par_en && b == DW + 1)   v = pbit;
            else                              v = ~bad_stop;
            for (int e = 0; e < pre; e++) begin
                drive_cycle(1'b1, (b == glitch_bit && e == glitch_edge) ? ~v : v, 5'(e), 4'(b));
            end
            if (dropped && b == drop_after) break;
        end
        if (!dropped) begin
            drive_cycle(1'b1, 1'b1, 5'd0, 4'(nbits));
            drive_cycle(1'b1, 1'b1, 5'd0, 4'(nbits));
        end
        repeat (4) drive_cycle(1'b0, 1'b1, 5'd0, 4'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        Prescale = 6'd16; RX_IN = 1'b1; sample_enable = 1'b0;
        edge_count = 5'd0; bit_count = 4'd0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (sampled_bit !== 1'b0) begin n_errors++; $display("FAIL reset sampled_bit: got %b want 0", sampled_bit); end
        n_checks++; if (sample_valid !== 1'b0) begin n_errors++; $display("FAIL reset sample_valid: got %b want 0", sample_valid); end
        n_checks++; if (P_DATA !== 8'h00) begin n_errors++; $display("FAIL reset P_DATA: got %h want 00", P_DATA); end
        n_checks++; if (data_valid !== 1'b0) begin n_errors++; $display("FAIL reset data_valid: got %b want 0", data_valid); end
        n_checks++; if (strt_glitch !== 1'b0) begin n_errors++; $display("FAIL reset strt_glitch: got %b want 0", strt_glitch); end
        n_checks++; if (par_err !== 1'b0) begin n_errors++; $display("FAIL reset par_err: got %b want 0", par_err); end
        n_checks++; if (stp_err !== 1'b0) begin n_errors++; $display("FAIL reset stp_err: got %b want 0", stp_err); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_clean_p16();
        mark();
        send_frame(16, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, -1);
        n_checks++; if (obs_counts() !== want_counts()) begin n_errors++; $display("FAIL clean_p16 counts dv/gl/par/stp/sv: got %h want %h", obs_counts(), want_counts()); end
        while (got_rd < got_q.size()) begin
            want_w = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
            n_checks++; if (got_q[got_rd] !== want_w) begin n_errors++; $display("FAIL clean_p16 word: got %h want %h", got_q[got_rd], want_w); end
            got_rd++;
        end
    endtask

    task automatic test_parity_p8();
        mark();
        send_frame(8, 8'h37, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, -1);
        send_frame(8, 8'h37, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1, -1);
        n_checks++; if (obs_counts() !== want_counts()) begin n_errors++; $display("FAIL parity_p8 counts dv/gl/par/stp/sv: got %h want %h", obs_counts(), want_counts()); end
        while (got_rd < got_q.size()) begin
            want_w = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
            n_checks++; if (got_q[got_rd] !== want_w) begin n_errors++; $display("FAIL parity_p8 word: got %h want %h", got_q[got_rd], want_w); end
            got_rd++;
        end
        n_checks++; if (P_DATA !== 8'h37) begin n_errors++; $display("FAIL parity_p8 held P_DATA: got %h want 37", P_DATA); end
    endtask

    task automatic test_start_glitch_p32();
        mark();
        send_frame(32, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1, -1);
        n_checks++; if (obs_counts() !== want_counts()) begin n_errors++; $display("FAIL start_glitch_p32 counts dv/gl/par/stp/sv: got %h want %h", obs_counts(), want_counts()); end
        n_checks++; if (P_DATA !== 8'h37) begin n_errors++; $display("FAIL start_glitch_p32 held P_DATA: got %h want 37", P_DATA); end
    endtask

    task automatic test_stop_err();
        mark();
        send_frame(16, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, -1);
        n_checks++; if (obs_counts() !== want_counts()) begin n_errors++; $display("FAIL stop_err counts dv/gl/par/stp/sv: got %h want %h", obs_counts(), want_counts()); end
        n_checks++; if (P_DATA !== 8'h37) begin n_errors++; $display("FAIL stop_err held P_DATA: got %h want 37", P_DATA); end
    endtask

    task automatic test_vote_glitch();
        mark();
        send_frame(16, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 8, -1);
        send_frame(16, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8, 9, -1);
        send_frame(8, 8'h6E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 3, -1);
        n_checks++; if (obs_counts() !== want_counts()) begin n_errors++; $display("FAIL vote_glitch counts dv/gl/par/stp/sv: got %h want %h", obs_counts(), want_counts()); end
        while (got_rd < got_q.size()) begin
            want_w = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
            n_checks++; if (got_q[got_rd] !== want_w) begin n_errors++; $display("FAIL vote_glitch word: got %h want %h", got_q[got_rd], want_w); end
            got_rd++;
        end
    endtask

    task automatic test_drop_midframe();
        mark();
        send_frame(16, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 4);
        n_checks++; if (P_DATA !== 8'h6E) begin n_errors++; $display("FAIL drop_midframe held P_DATA: got %h want 6e", P_DATA); end
        send_frame(16, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, -1);
        n_checks++; if (obs_counts() !== want_counts()) begin n_errors++; $display("FAIL drop_midframe counts dv/gl/par/stp/sv: got %h want %h", obs_counts(), want_counts()); end
        while (got_rd < got_q.size()) begin
            want_w = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
            n_checks++; if (got_q[got_rd] !== want_w) begin n_errors++; $display("FAIL drop_midframe word: got %h want %h", got_q[got_rd], want_w); end
            got_rd++;
        end
    endtask

    task automatic test_illegal_prescale();
        mark();
        send_frame(12, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, -1);
        n_checks++; if (obs_counts() !== want_counts()) begin n_errors++; $display("FAIL illegal_prescale counts dv/gl/par/stp/sv: got %h want %h", obs_counts(), want_counts()); end
        n_checks++; if (P_DATA !== 8'h0F) begin n_errors++; $display("FAIL illegal_prescale held P_DATA: got %h want 0f", P_DATA); end
    endtask

    task automatic test_back_to_back();
        mark();
        send_frame(8, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1, -1);
        send_frame(8, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1, -1);
        send_frame(8, 8'h12, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1, -1);
        send_frame(32, 8'hC6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1, -1);
        n_checks++; if (obs_counts() !== want_counts()) begin n_errors++; $display("FAIL back_to_back counts dv/gl/par/stp/sv: got %h want %h", obs_counts(), want_counts()); end
        while (got_rd < got_q.size()) begin
            want_w = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
            n_checks++; if (got_q[got_rd] !== want_w) begin n_errors++; $display("FAIL back_to_back word: got %h want %h", got_q[got_rd], want_w); end
            got_rd++;
        end
    endtask

    task automatic test_reset_midframe();
        Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        drive_cycle(1'b0, 1'b1, 5'd0, 4'd0);
        for (int e = 0; e < 8; e++) drive_cycle(1'b1, 1'b0, 5'(e), 4'd0);
        for (int e = 0; e < 7; e++) drive_cycle(1'b1, 1'b1, 5'(e), 4'd1);
        n_checks++; if ({sampled_bit, sample_valid} !== 2'b11) begin n_errors++; $display("FAIL reset_midframe vote before reset: got %b want 11", {sampled_bit, sample_valid}); end
        rst = 1'b1;
        drive_cycle(1'b1, 1'b1, 5'd7, 4'd1);
        n_checks++; if ({sampled_bit, sample_valid, data_valid, strt_glitch, par_err, stp_err} !== 6'b0) begin n_errors++; $display("FAIL reset_midframe flags: got %b want 000000", {sampled_bit, sample_valid, data_valid, strt_glitch, par_err, stp_err}); end
        n_checks++; if (P_DATA !== 8'h00) begin n_errors++; $display("FAIL reset_midframe P_DATA: got %h want 00", P_DATA); end
        rst = 1'b0;
        drive_cycle(1'b0, 1'b1, 5'd0, 4'd0);
        mark();
        send_frame(8, 8'hB4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, -1);
        n_checks++; if (obs_counts() !== want_counts()) begin n_errors++; $display("FAIL reset_midframe recovery counts: got %h want %h", obs_counts(), want_counts()); end
        while (got_rd < got_q.size()) begin
            want_w = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
            n_checks++; if (got_q[got_rd] !== want_w) begin n_errors++; $display("FAIL reset_midframe word: got %h want %h", got_q[got_rd], want_w); end
            got_rd++;
        end
    endtask

    initial begin
        test_reset();
        test_clean_p16();
        test_parity_p8();
        test_start_glitch_p32();
        test_stop_err();
        test_vote_glitch();
        test_drop_midframe();
        test_illegal_prescale();
        test_back_to_back();
        test_reset_midframe();
        n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL scoreboard leftover words: got %0d want 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
